// File: rtl/flit_rx_depacketizer_pkg.sv
// Shared definitions for the flit receive path: flit field layout helpers and FSM state codes.
package flit_rx_depacketizer_pkg;

    localparam logic ST_COLLECT = 1'b0;
    localparam logic ST_PRESENT = 1'b1;

    localparam int unsigned DATA_LSB = 0;

    function automatic int unsigned vc_bits_f(input int unsigned num_vcs);
        return (num_vcs > 1) ? $clog2(num_vcs) : 1;
    endfunction

    // Flit layout, MSB first: {valid, tail, dest, vc, data}
    function automatic int unsigned flit_w_f(input int unsigned dest_bits,
                                             input int unsigned num_vcs,
                                             input int unsigned data_w);
        return 2 + dest_bits + vc_bits_f(num_vcs) + data_w;
    endfunction

    function automatic int unsigned valid_bit_f(input int unsigned flit_w);
        return flit_w - 1;
    endfunction

    function automatic int unsigned tail_bit_f(input int unsigned flit_w);
        return flit_w - 2;
    endfunction

    function automatic int unsigned vc_lsb_f(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned dest_lsb_f(input int unsigned data_w,
                                               input int unsigned num_vcs);
        return data_w + vc_bits_f(num_vcs);
    endfunction

endpackage

// File: rtl/flit_rx_depacketizer_rx_flit_fifo.sv
// Synchronous flit FIFO with occupancy output; a push while full is dropped unless a pop
// frees the slot on the same edge.
module rx_flit_fifo
    import flit_rx_depacketizer_pkg::*;
#(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       CLK,
    input  logic                       nreset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge CLK or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/flit_rx_depacketizer.sv
// NoC receive stage: buffers ejected flits, returns credits and reassembles BLOCK_W-bit blocks.
// Define RX_LEN_CHECK_EN to enforce tail-on-last-flit framing and report len_err.
module flit_rx_depacketizer
    import flit_rx_depacketizer_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_VCS   = 2,
    parameter int unsigned DEST_BITS = 2,
    parameter int unsigned BUF_DEPTH = 8,
    parameter int unsigned BLOCK_W   = 1024
) (
    input  logic                                            CLK,
    input  logic                                            nreset,
    input  logic [flit_w_f(DEST_BITS, NUM_VCS, DATA_W)-1:0] getFlit,
    output logic                                            EN_getFlit,
    output logic [vc_bits_f(NUM_VCS):0]                     putCredits,
    output logic                                            EN_putCredits,
    output logic [BLOCK_W-1:0]                              blk_data,
    output logic                                            blk_valid,
    input  logic                                            blk_ready,
    output logic [$clog2(BUF_DEPTH):0]                      fifo_level,
    output logic                                            ovf_err,
    output logic                                            len_err
);

    localparam int unsigned VC_BITS   = vc_bits_f(NUM_VCS);
    localparam int unsigned FLIT_W    = flit_w_f(DEST_BITS, NUM_VCS, DATA_W);
    localparam int unsigned VALID_BIT = valid_bit_f(FLIT_W);
    localparam int unsigned TAIL_BIT  = tail_bit_f(FLIT_W);
    localparam int unsigned VC_LSB    = vc_lsb_f(DATA_W);
    localparam int unsigned DEST_LSB  = dest_lsb_f(DATA_W, NUM_VCS);
    localparam int unsigned ENT_W     = 1 + VC_BITS + DATA_W;
    localparam int unsigned FPB       = BLOCK_W / DATA_W;
    localparam int unsigned CNT_W     = (FPB > 1) ? $clog2(FPB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FPB - 1);

    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENT_W-1:0]   wr_ent;
    logic [ENT_W-1:0]   rd_ent;
    logic               rd_tail;
    logic [VC_BITS-1:0] rd_vc;
    logic [DATA_W-1:0]  rd_data;
    logic               last;
    logic               len_bad;

    logic               en_q;
    logic               cred_v_q;
    logic [VC_BITS-1:0] cred_vc_q;
    logic [BLOCK_W-1:0] blk_q;
    logic               state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;

    assign push    = getFlit[VALID_BIT];
    assign wr_ent  = {getFlit[TAIL_BIT], getFlit[VC_LSB +: VC_BITS], getFlit[DATA_LSB +: DATA_W]};
    assign rd_tail = rd_ent[ENT_W-1];
    assign rd_vc   = rd_ent[DATA_W +: VC_BITS];
    assign rd_data = rd_ent[DATA_W-1:0];
    assign pop     = (state_q == ST_COLLECT) && !empty;
    assign last    = (cnt_q == CNT_LAST);

    // Destination is resolved by the network; nothing to do with it here.
    logic unused_dest;
    assign unused_dest = ^getFlit[DEST_LSB +: DEST_BITS];

    rx_flit_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .nreset (nreset),
        .push   (push),
        .pop    (pop),
        .wdata  (wr_ent),
        .rdata  (rd_ent),
        .level  (fifo_level),
        .full   (full),
        .empty  (empty)
    );

`ifdef RX_LEN_CHECK_EN
    logic len_err_q;

    always_comb begin
        len_bad = 1'b0;
        if (pop) begin
            len_bad = (rd_tail != last);
        end
    end

    always_ff @(posedge CLK or negedge nreset) begin
        if (!nreset) begin
            len_err_q <= 1'b0;
        end else if (len_bad) begin
            len_err_q <= 1'b1;
        end
    end

    assign len_err = len_err_q;
`else
    logic unused_tail;
    assign unused_tail = rd_tail;
    assign len_bad     = 1'b0;
    assign len_err     = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nreset) begin
        if (!nreset) begin
            en_q      <= 1'b0;
            cred_v_q  <= 1'b0;
            cred_vc_q <= '0;
            blk_q     <= '0;
            state_q   <= ST_COLLECT;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            en_q      <= 1'b1;
            cred_v_q  <= pop;
            cred_vc_q <= pop ? rd_vc : '0;
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end
            if (state_q == ST_COLLECT) begin
                if (pop) begin
                    // A framing error drops the partial block but the flit's credit still returns.
                    if (len_bad) begin
                        cnt_q <= '0;
                    end else begin
                        blk_q <= {blk_q[BLOCK_W-DATA_W-1:0], rd_data};
                        if (last) begin
                            cnt_q   <= '0;
                            state_q <= ST_PRESENT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
            end else if (blk_ready) begin
                state_q <= ST_COLLECT;
            end
        end
    end

    assign EN_getFlit    = en_q;
    assign EN_putCredits = cred_v_q;
    assign putCredits    = {cred_v_q, cred_vc_q};
    assign blk_data      = blk_q;
    assign blk_valid     = (state_q == ST_PRESENT);
    assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_flit_rx_depacketizer.sv
// Directed scoreboard bench for flit_rx_depacketizer; follows RX_LEN_CHECK_EN when defined.
module tb_flit_rx_depacketizer;

    logic          CLK = 1'b0;
    logic          nreset = 1'b1;
    logic [36:0]   getFlit = '0;
    logic          EN_getFlit;
    logic [1:0]    putCredits;
    logic          EN_putCredits;
    logic [1023:0] blk_data;
    logic          blk_valid;
    logic          blk_ready = 1'b0;
    logic [3:0]    fifo_level;
    logic          ovf_err;
    logic          len_err;

    flit_rx_depacketizer #(
        .DATA_W    (32),
        .NUM_VCS   (2),
        .DEST_BITS (2),
        .BUF_DEPTH (8),
        .BLOCK_W   (1024)
    ) dut (
        .CLK           (CLK),
        .nreset        (nreset),
        .getFlit       (getFlit),
        .EN_getFlit    (EN_getFlit),
        .putCredits    (putCredits),
        .EN_putCredits (EN_putCredits),
        .blk_data      (blk_data),
        .blk_valid     (blk_valid),
        .blk_ready     (blk_ready),
        .fifo_level    (fifo_level),
        .ovf_err       (ovf_err),
        .len_err       (len_err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic          cred_q[$];
    logic [1023:0] blk_q[$];
    logic [1023:0] m_blk = '0;
    int            m_cnt = 0;
    logic          m_len_err = 1'b0;

    int            cred_cnt = 0;
    int            first_cred_cyc = -1;
    int            last_cred_cyc = 0;
    int            blk_seen = 0;
    int            blk_rise_cyc = 0;
    logic          prev_v = 1'b0;
    logic [1023:0] last_blk = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input logic [1023:0] obs, input logic [1023:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL blk_data observed_lo=%0h expected_lo=%0h observed_hi=%0h expected_hi=%0h",
                   obs[63:0], exp[63:0], obs[1023:960], exp[1023:960]);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Drive one flit for one cycle; acc=0 marks a flit the DUT must drop.
    task automatic send(input logic [31:0] d, input logic vc, input logic tail, input logic acc);
        logic lbad;
        getFlit = {1'b1, tail, 2'($urandom_range(3)), vc, d};
        if (acc) begin
            cred_q.push_back(vc);
            lbad = 1'b0;
`ifdef RX_LEN_CHECK_EN
            if (tail != (m_cnt == 31)) begin
                lbad = 1'b1;
                m_cnt = 0;
                m_len_err = 1'b1;
            end
`endif
            if (!lbad) begin
                m_blk = {m_blk[991:0], d};
                m_cnt++;
                if (m_cnt == 32) begin
                    blk_q.push_back(m_blk);
                    m_cnt = 0;
                end
            end
        end
        @(posedge CLK);
        #1;
        getFlit = '0;
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            cyc = cyc + 1;
        end
    end

    initial begin
        logic e;
        forever begin
            @(negedge CLK);
            if (nreset) begin
                if (EN_putCredits) begin
                    cred_cnt++;
                    if (first_cred_cyc < 0) first_cred_cyc = cyc;
                    last_cred_cyc = cyc;
                    chk("credit_pending", 64'(cred_q.size() > 0), 64'd1);
                    if (cred_q.size() > 0) begin
                        e = cred_q.pop_front();
                        chk("credit_value", 64'(putCredits), 64'({1'b1, e}));
                    end
                end
                if (blk_valid && !prev_v) blk_rise_cyc = cyc;
                prev_v = blk_valid;
                if (blk_valid && blk_ready) begin
                    blk_seen++;
                    last_blk = blk_data;
                    chk("blk_pending", 64'(blk_q.size() > 0), 64'd1);
                    if (blk_q.size() > 0) chk_blk(blk_data, blk_q.pop_front());
                end
            end else begin
                prev_v = 1'b0;
            end
        end
    end

    initial begin
        int t0;
        int t_last;
        int c0;
        int b0;

        #1 nreset = 1'b0;
        #1;
        chk("rst_en_get", 64'(EN_getFlit), 64'd0);
        chk("rst_en_put", 64'(EN_putCredits), 64'd0);
        chk("rst_put_credits", 64'(putCredits), 64'd0);
        chk("rst_blk_valid", 64'(blk_valid), 64'd0);
        chk("rst_blk_zero", 64'(|blk_data), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_ovf", 64'(ovf_err), 64'd0);
        chk("rst_len", 64'(len_err), 64'd0);
        tick(2);
        nreset = 1'b1;
        tick(2);
        chk("en_get_after_reset", 64'(EN_getFlit), 64'd1);

        // Clean block, back-to-back, downstream always ready
        blk_ready = 1'b1;
        t0 = cyc;
        t_last = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) t_last = cyc;
            send(32'(i), 1'b0, i == 31, 1'b1);
        end
        tick(6);
        chk("t1_credit_latency", 64'(first_cred_cyc - t0), 64'd2);
        chk("t1_credit_count", 64'(cred_cnt), 64'd32);
        chk("t1_credit_spacing", 64'(last_cred_cyc - first_cred_cyc), 64'd31);
        chk("t1_blk_latency", 64'(blk_rise_cyc - t_last), 64'd2);
        chk("t1_blk_seen", 64'(blk_seen), 64'd1);
        chk("t1_blk_msw", 64'(last_blk[1023:992]), 64'd0);
        chk("t1_blk_lsw", 64'(last_blk[31:0]), 64'd31);

        // Downstream stalls: FIFO fills, credits are withheld
        blk_ready = 1'b0;
        for (int i = 0; i < 32; i++) send(32'(100 + i), 1'b0, i == 31, 1'b1);
        tick(3);
        c0 = cred_cnt;
        for (int i = 0; i < 8; i++) send(32'(200 + i), 1'b0, 1'b0, 1'b1);
        tick(3);
        chk("t2_level", 64'(fifo_level), 64'd8);
        chk("t2_no_credits", 64'(cred_cnt - c0), 64'd0);
        chk("t2_no_ovf", 64'(ovf_err), 64'd0);
        chk("t2_blk_valid", 64'(blk_valid), 64'd1);

        // Overflow while full and presenting
        send(32'hDEAD, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk("t3_ovf", 64'(ovf_err), 64'd1);
        chk("t3_level", 64'(fifo_level), 64'd8);
        c0 = cred_cnt;
        blk_ready = 1'b1;
        tick(12);
        chk("t3_drain_credits", 64'(cred_cnt - c0), 64'd8);
        chk("t3_level_empty", 64'(fifo_level), 64'd0);
        chk("t3_blk_seen", 64'(blk_seen), 64'd2);

        // Mixed VCs complete the block that the buffered flits started
        c0 = cred_cnt;
        for (int i = 0; i < 24; i++) send(32'(300 + i), 1'(i), i == 23, 1'b1);
        tick(6);
        chk("t4_credits", 64'(cred_cnt - c0), 64'd24);
        chk("t4_blk_seen", 64'(blk_seen), 64'd3);

        // Early tail
        for (int i = 0; i < 6; i++) send(32'(500 + i), 1'b0, i == 5, 1'b1);
        for (int i = 0; i < 32; i++) send(32'(600 + i), 1'b1, i == 31, 1'b1);
        tick(10);
        chk("t5_len_err", 64'(len_err), 64'(m_len_err));
        chk("t5_blk_seen", 64'(blk_seen), 64'd4);
        chk("t5_ovf_sticky", 64'(ovf_err), 64'd1);

        // Reset mid-block
        for (int i = 0; i < 10; i++) send(32'(700 + i), 1'b0, 1'b0, 1'b1);
        tick(2);
        nreset = 1'b0;
        #1;
        chk("t6_en_get", 64'(EN_getFlit), 64'd0);
        chk("t6_en_put", 64'(EN_putCredits), 64'd0);
        chk("t6_put_credits", 64'(putCredits), 64'd0);
        chk("t6_blk_valid", 64'(blk_valid), 64'd0);
        chk("t6_blk_zero", 64'(|blk_data), 64'd0);
        chk("t6_level", 64'(fifo_level), 64'd0);
        chk("t6_ovf", 64'(ovf_err), 64'd0);
        chk("t6_len", 64'(len_err), 64'd0);
        cred_q.delete();
        blk_q.delete();
        m_cnt = 0;
        m_blk = '0;
        m_len_err = 1'b0;
        tick(2);
        nreset = 1'b1;
        tick(2);
        b0 = blk_seen;
        for (int i = 0; i < 32; i++) send(32'(800 + i), 1'b1, i == 31, 1'b1);
        tick(8);
        chk("t6_blk_after_reset", 64'(blk_seen - b0), 64'd1);
        chk("t6_blk_lsw", 64'(last_blk[31:0]), 64'd831);
        chk("t6_blk_msw", 64'(last_blk[1023:992]), 64'd800);
        chk("t6_len_clean", 64'(len_err), 64'd0);
        chk("end_credit_queue", 64'(cred_q.size()), 64'd0);
        chk("end_blk_queue", 64'(blk_q.size()), 64'd0);
        chk("end_level", 64'(fifo_level), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
